// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: types and helpers shared by the FIFO write arbiter.
//   arb_state_e : arbiter sequencer states (normal, drain-for-flush, flush).
//   idw(n)      : source-ID width for n requesters, never less than 1 bit.
//   NREQ_DEF / DATA_W_DEF : default requester count and payload width.
package fifo_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } arb_state_e;

  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request vector, one bit per requester.
//   ptr    : index holding highest priority; priority then ascends with wrap.
//   gnt    : one-hot grant (all zero when nothing requests).
//   gnt_id : index of the granted requester (0 when nothing requests).
//   any    : at least one requester was granted.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int ID_W = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter and flush sequencer in front of a
// shared synchronous FIFO.
//   clk, rst              : clock, synchronous active-high reset.
//   req_vld/data/last     : per-requester beat valid, payload, end-of-packet.
//   req_rdy               : per-requester accept, at most one bit high.
//   fifo_we/fifo_wd       : FIFO write strobe and {source_id, payload} word.
//   fifo_full, fifo_len   : FIFO status inputs.
//   fifo_fsh              : FIFO flush strobe.
//   flush_req/flush_done  : flush request (level or pulse) and issue pulse.
//   lock_vld/lock_id      : packet in progress and its owner.
//   occ                   : registered copy of fifo_len.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ   = NREQ_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int FIFO_D = 12,
  localparam int ID_W   = idw(NREQ),
  localparam int LEN_W  = $clog2(FIFO_D) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_vld,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_rdy,
  output logic                         fifo_we,
  output logic [ID_W+DATA_W-1:0]       fifo_wd,
  input  logic                         fifo_full,
  input  logic [LEN_W-1:0]             fifo_len,
  output logic                         fifo_fsh,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         lock_vld,
  output logic [ID_W-1:0]              lock_id,
  output logic [LEN_W-1:0]             occ
);

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] acc_id;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] gnt;
  logic            pick_any;
  logic            acc;
  logic            lock_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_vld),
    .ptr    (rr_ptr),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    req_rdy    = '0;
    fifo_fsh   = 1'b0;
    flush_done = 1'b0;
    acc_id     = lock_vld ? lock_id : pick_id;
    lock_nxt   = lock_vld;

    // A held lock pins the grant to its owner even if it drops valid, so a
    // bubble appears rather than another requester interleaving. New packets
    // only start in IDLE; DRAIN serves the lock owner alone.
    if (lock_vld)
      gnt = NREQ'(1) << lock_id;
    else if (state == IDLE && pick_any)
      gnt = pick_gnt;

    if (!rst && state != FLUSH && !fifo_full)
      req_rdy = gnt;

    acc     = |(req_vld & req_rdy);
    fifo_we = acc;
    fifo_wd = {acc_id, req_data[acc_id]};

    if (acc)
      lock_nxt = ~req_last[acc_id];

    // Flush decisions look at the lock as it will be after this cycle, so a
    // packet whose first beat is accepted alongside flush_req still drains.
    case (state)
      IDLE:  if (flush_req) state_nxt = lock_nxt ? DRAIN : FLUSH;
      DRAIN: if (!lock_nxt) state_nxt = FLUSH;
      FLUSH: begin
        fifo_fsh   = !rst;
        flush_done = !rst;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it acts only on a clock edge with rst high.
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      occ      <= '0;
    end else begin
      state    <= state_nxt;
      occ      <= fifo_len;
      lock_vld <= lock_nxt;
      if (acc) begin
        if (req_last[acc_id])
          rr_ptr <= ID_W'((int'(acc_id) + 1) % NREQ);
        else
          lock_id <= acc_id;
      end
      if (state == FLUSH)
        rr_ptr <= '0;
    end
  end

  a_rdy_onehot0: assert property (@(posedge clk) $onehot0(req_rdy));
  a_we_not_full: assert property (@(posedge clk) fifo_we |-> !fifo_full);
  a_no_fsh_we:   assert property (@(posedge clk) !(fifo_fsh && fifo_we));
  a_lock_stable: assert property (@(posedge clk) disable iff (rst)
                                  lock_vld |=> $stable(lock_id));

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb (4 requesters,
// 32-bit payload). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_fifo_wr_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_vld;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_last;
  logic [3:0]       req_rdy;
  logic             fifo_we;
  logic [33:0]      fifo_wd;
  logic             fifo_full;
  logic [4:0]       fifo_len;
  logic             fifo_fsh;
  logic             flush_req;
  logic             flush_done;
  logic             lock_vld;
  logic [1:0]       lock_id;
  logic [4:0]       occ;

  // Packed control view: {req_rdy[3:0], fifo_we, fifo_fsh, flush_done, lock_vld}
  logic [7:0]       ctl;
  assign ctl = {req_rdy, fifo_we, fifo_fsh, flush_done, lock_vld};

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] last;
    logic       full;
    logic       flush;
    logic [7:0] ctl;
    logic [1:0] id;
  } vec_t;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(4), .DATA_W(32), .FIFO_D(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .fifo_we    (fifo_we),
    .fifo_wd    (fifo_wd),
    .fifo_full  (fifo_full),
    .fifo_len   (fifo_len),
    .fifo_fsh   (fifo_fsh),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .lock_vld   (lock_vld),
    .lock_id    (lock_id),
    .occ        (occ)
  );

  function automatic logic [31:0] pay(input int i, input int c);
    return {8'(i + 1), 16'h5A5A, 8'(c)};
  endfunction

  task automatic apply(input vec_t v, input int c);
    req_vld   = v.vld;
    req_last  = v.last;
    fifo_full = v.full;
    flush_req = v.flush;
    for (int i = 0; i < 4; i++) req_data[i] = pay(i, c);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'h00);
    end
    tests++;
    if (occ !== 5'd0) begin
      fails++; $display("FAIL reset_occ: got %0d want 0", occ);
    end
    next_cycle();
    rst = 1'b0; req_vld = 4'b0000; req_last = 4'b0000;
    @(negedge clk);
    tests++;
    if (ctl !== 8'h00) begin
      fails++; $display("FAIL reset_idle_ctl: got %b want %b", ctl, 8'h00);
    end
    next_cycle();
    fifo_len = 5'd0;
    @(negedge clk);
    tests++;
    if (occ !== 5'd5) begin
      fails++; $display("FAIL occ_copy: got %0d want 5", occ);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      int id;
      id = c % 4;
      apply('{4'b1111, 4'b1111, 1'b0, 1'b0, 8'h00, 2'd0}, c);
      @(negedge clk);
      tests++;
      if (ctl !== {4'(1 << id), 4'b1000}) begin
        fails++; $display("FAIL rr_ctl c%0d: got %b want %b", c, ctl, {4'(1 << id), 4'b1000});
      end
      tests++;
      if (fifo_wd !== {2'(id), pay(id, c)}) begin
        fails++; $display("FAIL rr_wd c%0d: got %h want %h", c, fifo_wd, {2'(id), pay(id, c)});
      end
      next_cycle();
    end
    req_vld = 4'b0000;
  endtask

  task automatic test_lock();
    vec_t v [4] = '{
      '{4'b0010, 4'b0000, 1'b0, 1'b0, 8'b0010_1000, 2'd1},
      '{4'b0111, 4'b0000, 1'b0, 1'b0, 8'b0010_1001, 2'd1},
      '{4'b0111, 4'b0010, 1'b0, 1'b0, 8'b0010_1001, 2'd1},
      '{4'b0101, 4'b0100, 1'b0, 1'b0, 8'b0100_1000, 2'd2}
    };
    for (int c = 0; c < 4; c++) begin
      apply(v[c], c);
      @(negedge clk);
      tests++;
      if (ctl !== v[c].ctl) begin
        fails++; $display("FAIL lock_ctl c%0d: got %b want %b", c, ctl, v[c].ctl);
      end
      if (v[c].ctl[3]) begin
        tests++;
        if (fifo_wd !== {v[c].id, pay(int'(v[c].id), c)}) begin
          fails++; $display("FAIL lock_wd c%0d: got %h want %h", c, fifo_wd, {v[c].id, pay(int'(v[c].id), c)});
        end
      end
      if (v[c].ctl[0]) begin
        tests++;
        if (lock_id !== 2'd1) begin
          fails++; $display("FAIL lock_id c%0d: got %0d want 1", c, lock_id);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_full_stall();
    vec_t v [10] = '{
      '{4'b1001, 4'b0000, 1'b0, 1'b0, 8'b1000_1000, 2'd3},
      '{4'b1001, 4'b0000, 1'b1, 1'b0, 8'b0000_0001, 2'd3},
      '{4'b1001, 4'b0000, 1'b1, 1'b0, 8'b0000_0001, 2'd3},
      '{4'b1001, 4'b0000, 1'b1, 1'b0, 8'b0000_0001, 2'd3},
      '{4'b1001, 4'b0000, 1'b1, 1'b0, 8'b0000_0001, 2'd3},
      '{4'b1001, 4'b0000, 1'b1, 1'b0, 8'b0000_0001, 2'd3},
      '{4'b0001, 4'b0000, 1'b0, 1'b0, 8'b1000_0001, 2'd3},
      '{4'b1001, 4'b0000, 1'b0, 1'b0, 8'b1000_1001, 2'd3},
      '{4'b1001, 4'b1000, 1'b0, 1'b0, 8'b1000_1001, 2'd3},
      '{4'b0001, 4'b0001, 1'b0, 1'b0, 8'b0001_1000, 2'd0}
    };
    for (int c = 0; c < 10; c++) begin
      apply(v[c], c);
      @(negedge clk);
      tests++;
      if (ctl !== v[c].ctl) begin
        fails++; $display("FAIL full_ctl c%0d: got %b want %b", c, ctl, v[c].ctl);
      end
      if (v[c].ctl[3]) begin
        tests++;
        if (fifo_wd !== {v[c].id, pay(int'(v[c].id), c)}) begin
          fails++; $display("FAIL full_wd c%0d: got %h want %h", c, fifo_wd, {v[c].id, pay(int'(v[c].id), c)});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_drain_flush();
    vec_t v [6] = '{
      '{4'b0100, 4'b0000, 1'b0, 1'b0, 8'b0100_1000, 2'd2},
      '{4'b0101, 4'b0000, 1'b0, 1'b1, 8'b0100_1001, 2'd2},
      '{4'b0101, 4'b0000, 1'b0, 1'b0, 8'b0100_1001, 2'd2},
      '{4'b0101, 4'b0100, 1'b0, 1'b0, 8'b0100_1001, 2'd2},
      '{4'b1001, 4'b1001, 1'b0, 1'b0, 8'b0000_0110, 2'd0},
      '{4'b1001, 4'b1001, 1'b0, 1'b0, 8'b0001_1000, 2'd0}
    };
    for (int c = 0; c < 6; c++) begin
      apply(v[c], c);
      @(negedge clk);
      tests++;
      if (ctl !== v[c].ctl) begin
        fails++; $display("FAIL drain_ctl c%0d: got %b want %b", c, ctl, v[c].ctl);
      end
      if (v[c].ctl[3]) begin
        tests++;
        if (fifo_wd !== {v[c].id, pay(int'(v[c].id), c)}) begin
          fails++; $display("FAIL drain_wd c%0d: got %h want %h", c, fifo_wd, {v[c].id, pay(int'(v[c].id), c)});
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush_level();
    vec_t v [5] = '{
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 8'b0000_0000, 2'd0},
      '{4'b0010, 4'b0010, 1'b0, 1'b1, 8'b0000_0110, 2'd0},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 8'b0000_0000, 2'd0},
      '{4'b0010, 4'b0010, 1'b0, 1'b0, 8'b0000_0110, 2'd0},
      '{4'b1001, 4'b1001, 1'b0, 1'b0, 8'b0001_1000, 2'd0}
    };
    for (int c = 0; c < 5; c++) begin
      apply(v[c], c);
      @(negedge clk);
      tests++;
      if (ctl !== v[c].ctl) begin
        fails++; $display("FAIL level_ctl c%0d: got %b want %b", c, ctl, v[c].ctl);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_packet();
    apply('{4'b0010, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0}, 0);
    @(negedge clk);
    tests++;
    if (ctl !== 8'b0010_1000) begin
      fails++; $display("FAIL rstpk_c0: got %b want %b", ctl, 8'b0010_1000);
    end
    next_cycle();
    apply('{4'b0011, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0}, 1);
    @(negedge clk);
    tests++;
    if (ctl !== 8'b0010_1001) begin
      fails++; $display("FAIL rstpk_c1: got %b want %b", ctl, 8'b0010_1001);
    end
    next_cycle();
    rst = 1'b1; fifo_len = 5'd7;
    apply('{4'b0011, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0}, 2);
    @(negedge clk);
    tests++;
    if (ctl !== 8'b0000_0001) begin
      fails++; $display("FAIL rstpk_in_rst: got %b want %b", ctl, 8'b0000_0001);
    end
    next_cycle();
    rst = 1'b0; fifo_len = 5'd0;
    apply('{4'b0011, 4'b0011, 1'b0, 1'b0, 8'h00, 2'd0}, 3);
    @(negedge clk);
    tests++;
    if (ctl !== 8'b0001_1000) begin
      fails++; $display("FAIL rstpk_after: got %b want %b", ctl, 8'b0001_1000);
    end
    tests++;
    if (fifo_wd !== {2'd0, pay(0, 3)}) begin
      fails++; $display("FAIL rstpk_wd: got %h want %h", fifo_wd, {2'd0, pay(0, 3)});
    end
    tests++;
    if (occ !== 5'd0) begin
      fails++; $display("FAIL rstpk_occ: got %0d want 0", occ);
    end
    next_cycle();
    req_vld = 4'b0000;
  endtask

  initial begin
    rst       = 1'b1;
    req_vld   = 4'b1111;
    req_last  = 4'b1111;
    req_data  = '0;
    fifo_full = 1'b0;
    fifo_len  = 5'd5;
    flush_req = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full_stall();
    test_drain_flush();
    test_flush_level();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
